// File: rtl/blk_pkg.sv
// Shared constants and types for the block-statistics scan path.
package blk_pkg;

   localparam int unsigned PIX_W     = 24;
   localparam int unsigned HBLKS_DEF = 10;
   localparam int unsigned VBLKS_DEF = 10;
   localparam int unsigned BW_DEF    = 30;
   localparam int unsigned BH_DEF    = 30;

   typedef logic [PIX_W-1:0] pix_t;

   typedef struct packed {
      logic de;
      pix_t wd;
      logic h_save;
      logic v_save;
      logic in_grid;
      logic err;
   } stage1_t;

endpackage

// File: rtl/blk_wrap_cnt.sv
// Wrapping counter 0..MAX; clear takes priority and an inc in the same cycle counts from 0.
module blk_wrap_cnt
   import blk_pkg::*;
#(
   parameter int unsigned MAX = 1,
   parameter int unsigned W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] value,
   output logic         at_max
);

   logic [W-1:0] base;

   always_comb begin
      base = clear ? '0 : value;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         value <= '0;
      end else if (inc) begin
         value <= (base == W'(MAX)) ? '0 : base + W'(1);
      end else if (clear) begin
         value <= '0;
      end
   end

   assign at_max = (value == W'(MAX));

endmodule

// File: rtl/blk_scan.sv
// Raster tracker for the block grid: issues save strobes to blk_buffer and
// inverts pixels of flagged blocks on the outgoing video.
module blk_scan
   import blk_pkg::*;
#(
   parameter int unsigned HBLKS = HBLKS_DEF,
   parameter int unsigned VBLKS = VBLKS_DEF,
   parameter int unsigned BW    = BW_DEF,
   parameter int unsigned BH    = BH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             vs_i,
   input  logic             hs_i,
   input  logic             de_i,
   input  logic [PIX_W-1:0] data_i,
   input  logic             en_i,
   output logic             de_o,
   output logic [PIX_W-1:0] wd_o,
   output logic             h_save_o,
   output logic             v_save_o,
   input  logic             rx_i,
   output logic             vid_vs_o,
   output logic             vid_hs_o,
   output logic             vid_de_o,
   output logic [PIX_W-1:0] vid_data_o,
   output logic             err_o
);

   localparam int unsigned PXW = (BW > 1) ? $clog2(BW) : 1;
   localparam int unsigned HBW = $clog2(HBLKS + 1);
   localparam int unsigned LNW = (BH > 1) ? $clog2(BH) : 1;
   localparam int unsigned VBW = $clog2(VBLKS + 1);

   stage1_t        s1_d, s1_q;
   logic           vs_q, hs_q, synced;
   logic [PXW-1:0] px;
   logic [HBW-1:0] hb;
   logic [LNW-1:0] ln;
   logic [VBW-1:0] vb;
   logic           px_at_max, hb_at_max, ln_at_max, vb_at_max;
   logic           vs_rise, line_end, line_clr;
   logic           grid_px, px_last, hb_last, ln_last;
   logic           h_save, v_save, ln_inc, vb_inc;
   logic           short_line, short_frame, invert;

   // Only terminal flags of px/ln matter here; their raw values are not consumed.
   logic unused_val;
   assign unused_val = ^{px, ln};

   // A vs rise restarts the frame in the same cycle, so a coincident pixel
   // is judged against the cleared counters rather than the stale ones.
   always_comb begin
      vs_rise     = vs_i && !vs_q;
      line_end    = !de_i && s1_q.de;
      line_clr    = vs_rise || line_end;
      grid_px     = de_i && (synced || vs_rise) &&
                    (vs_rise || (!vb_at_max && !hb_at_max));
      px_last     = vs_rise ? (BW == 1)    : px_at_max;
      hb_last     = vs_rise ? (HBLKS == 1) : (hb == HBW'(HBLKS - 1));
      ln_last     = vs_rise ? (BH == 1)    : ln_at_max;
      h_save      = grid_px && px_last;
      v_save      = h_save && hb_last && ln_last;
      ln_inc      = line_end && !vs_rise && synced && !vb_at_max;
      vb_inc      = ln_inc && ln_at_max;
      short_line  = ln_inc && (hb != '0) && !hb_at_max;
      short_frame = vs_rise && synced && (vb != VBW'(VBLKS));
   end

   blk_wrap_cnt #(.MAX(BW - 1), .W(PXW)) u_px (
      .clk_i (clk_i), .rst_ni (rst_ni), .clear (line_clr), .inc (grid_px),
      .value (px), .at_max (px_at_max)
   );

   blk_wrap_cnt #(.MAX(HBLKS), .W(HBW)) u_hb (
      .clk_i (clk_i), .rst_ni (rst_ni), .clear (line_clr), .inc (h_save),
      .value (hb), .at_max (hb_at_max)
   );

   blk_wrap_cnt #(.MAX(BH - 1), .W(LNW)) u_ln (
      .clk_i (clk_i), .rst_ni (rst_ni), .clear (vs_rise), .inc (ln_inc),
      .value (ln), .at_max (ln_at_max)
   );

   blk_wrap_cnt #(.MAX(VBLKS), .W(VBW)) u_vb (
      .clk_i (clk_i), .rst_ni (rst_ni), .clear (vs_rise), .inc (vb_inc),
      .value (vb), .at_max (vb_at_max)
   );

   always_comb begin
      s1_d = '{de: de_i, wd: data_i, h_save: h_save, v_save: v_save,
               in_grid: grid_px, err: short_line || short_frame};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q   <= '0;
         vs_q   <= 1'b0;
         hs_q   <= 1'b0;
         synced <= 1'b0;
      end else begin
         s1_q <= s1_d;
         vs_q <= vs_i;
         hs_q <= hs_i;
         if (vs_rise) synced <= 1'b1;
      end
   end

   assign invert = en_i && rx_i && s1_q.in_grid;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vid_vs_o   <= 1'b0;
         vid_hs_o   <= 1'b0;
         vid_de_o   <= 1'b0;
         vid_data_o <= '0;
      end else begin
         vid_vs_o   <= vs_q;
         vid_hs_o   <= hs_q;
         vid_de_o   <= s1_q.de;
         vid_data_o <= invert ? ~s1_q.wd : s1_q.wd;
      end
   end

   assign de_o     = s1_q.de;
   assign wd_o     = s1_q.wd;
   assign h_save_o = s1_q.h_save;
   assign v_save_o = s1_q.v_save;
   assign err_o    = s1_q.err;

endmodule

// File: tb/tb_blk_scan.sv
// Bench for blk_scan on a 4x3 grid of 8x2 blocks, with a blk_buffer-like rx_i source.
module tb_blk_scan;
   import blk_pkg::*;

   localparam int HB = 4;
   localparam int VB = 3;
   localparam int BW = 8;
   localparam int BH = 2;
   localparam int CB = $clog2(HB);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              vs = 1'b0, hs = 1'b0, de = 1'b0, en = 1'b0, rx;
   logic [PIX_W-1:0]  data = '0;
   logic              de_o, h_save_o, v_save_o, err_o;
   logic              vid_vs_o, vid_hs_o, vid_de_o;
   logic [PIX_W-1:0]  wd_o, vid_data_o;

   blk_scan #(.HBLKS(HB), .VBLKS(VB), .BW(BW), .BH(BH)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .vs_i       (vs),
      .hs_i       (hs),
      .de_i       (de),
      .data_i     (data),
      .en_i       (en),
      .de_o       (de_o),
      .wd_o       (wd_o),
      .h_save_o   (h_save_o),
      .v_save_o   (v_save_o),
      .rx_i       (rx),
      .vid_vs_o   (vid_vs_o),
      .vid_hs_o   (vid_hs_o),
      .vid_de_o   (vid_de_o),
      .vid_data_o (vid_data_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   // blk_buffer stand-in: column decision advances on each h_save edge, restarts per line.
   logic [HB-1:0] flags = '0;
   int            col_ptr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)        col_ptr <= 0;
      else if (!de_o)    col_ptr <= 0;
      else if (h_save_o) col_ptr <= col_ptr + 1;
   end

   always_comb begin
      rx = 1'b0;
      if (col_ptr < HB) rx = flags[CB'(col_ptr)];
   end

   // Reference model: position from pixel/line counts, expectations per input cycle.
   typedef struct packed {
      logic             vs, hs, de;
      logic [PIX_W-1:0] d;
      logic             h, v, err, inv;
   } exp_t;

   exp_t hist[$];
   bit   m_synced, m_vs_prev, m_de_prev;
   int   m_idx, m_line;
   int   n_checks = 0, n_errors = 0;
   int   cnt_h, cnt_v, cnt_e, cnt_inv;

   task automatic reset_model();
      m_synced = 0; m_vs_prev = 0; m_de_prev = 0; m_idx = 0; m_line = 0;
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
   endtask

   task automatic chk_int(input string name, input int act, input int want);
      n_checks++;
      if (act != want) begin
         n_errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, want);
      end
   endtask

   task automatic check_outputs();
      exp_t s1, s2;
      logic [27:0] e1, a1;
      logic [26:0] e2, a2;
      s1 = hist[hist.size() - 1];
      s2 = hist[hist.size() - 2];
      e1 = {s1.de, s1.d, s1.h, s1.v, s1.err};
      a1 = {de_o, wd_o, h_save_o, v_save_o, err_o};
      n_checks++;
      if (a1 !== e1) begin
         n_errors++;
         $display("FAIL stage1 @%0t: de/wd/h/v/err got %h want %h", $time, a1, e1);
      end
      e2 = {s2.vs, s2.hs, s2.de, s2.inv ? ~s2.d : s2.d};
      a2 = {vid_vs_o, vid_hs_o, vid_de_o, vid_data_o};
      n_checks++;
      if (a2 !== e2) begin
         n_errors++;
         $display("FAIL video @%0t: vs/hs/de/data got %h want %h", $time, a2, e2);
      end
      cnt_h   += h_save_o ? 1 : 0;
      cnt_v   += v_save_o ? 1 : 0;
      cnt_e   += err_o ? 1 : 0;
      cnt_inv += (vid_de_o && vid_data_o == ~s2.d) ? 1 : 0;
   endtask

   task automatic drive(input logic vs_v, input logic hs_v, input logic de_v,
                        input logic [PIX_W-1:0] d_v);
      exp_t e;
      bit   vs_rise, line_end;
      int   hbk, col, row;
      e = '0;
      if (rst_n) begin
         e.vs = vs_v; e.hs = hs_v; e.de = de_v; e.d = d_v;
         vs_rise  = vs_v && !m_vs_prev;
         line_end = !de_v && m_de_prev;
         if (vs_rise) begin
            if (m_synced && m_line < VB * BH) e.err = 1'b1;
            m_synced = 1; m_idx = 0; m_line = 0;
         end else if (line_end) begin
            if (m_synced && m_line < VB * BH) begin
               hbk = m_idx / BW;
               if (hbk > 0 && hbk < HB) e.err = 1'b1;
               m_line++;
            end
            m_idx = 0;
         end
         if (de_v) begin
            col = m_idx / BW;
            row = m_line / BH;
            if (m_synced && col < HB && row < VB) begin
               e.h   = (m_idx % BW) == BW - 1;
               e.v   = e.h && col == HB - 1 && (m_line % BH) == BH - 1;
               e.inv = en && flags[CB'(col)];
            end
            m_idx++;
         end
         m_vs_prev = vs_v;
         m_de_prev = de_v;
      end
      vs = vs_v; hs = hs_v; de = de_v; data = d_v;
      hist.push_back(e);
      if (hist.size() > 2) hist.delete(0);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic send_line(input int len, input logic [PIX_W-1:0] fixed, input int vs_cycles);
      logic [31:0] r;
      for (int p = 0; p < len; p++) begin
         r = $urandom();
         drive(p < vs_cycles, 1'b0, 1'b1, (fixed != '0) ? fixed : r[PIX_W-1:0]);
      end
      drive(1'b0, 1'b0, 1'b0, '0);
      drive(1'b0, 1'b1, 1'b0, '0);
      drive(1'b0, 1'b1, 1'b0, '0);
      drive(1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic run_frame(input int nlines, input int len, input bit en_v,
                            input logic [HB-1:0] fl, input logic [PIX_W-1:0] fixed,
                            input bit vs_on_de);
      en = en_v;
      flags = fl;
      if (!vs_on_de) begin
         drive(1'b1, 1'b0, 1'b0, '0);
         drive(1'b1, 1'b0, 1'b0, '0);
         idle(2);
      end
      for (int l = 0; l < nlines; l++) send_line(len, fixed, (vs_on_de && l == 0) ? 2 : 0);
      idle(4);
   endtask

   typedef struct {
      int               nlines;
      int               len;
      bit               en;
      logic [HB-1:0]    fl;
      logic [PIX_W-1:0] fixed;
      int               exp_h, exp_v, exp_e, exp_inv;
   } vec_t;

   vec_t tbl[11];
   int   lens[6];

   initial begin
      //            lines len en flags    fixed        h   v  err inv
      tbl[0]  = '{6, 32, 1'b1, 4'b0000, 24'h000000, 24, 3, 0,  0};
      tbl[1]  = '{6, 32, 1'b1, 4'b0100, 24'h123456, 24, 3, 0, 48};
      tbl[2]  = '{6, 32, 1'b0, 4'b0100, 24'h000000, 24, 3, 0,  0};
      tbl[3]  = '{6, 40, 1'b1, 4'b1000, 24'h000000, 24, 3, 0, 48};
      tbl[4]  = '{4, 32, 1'b1, 4'b0000, 24'h000000, 16, 2, 0,  0};
      tbl[5]  = '{6, 32, 1'b1, 4'b0000, 24'h000000, 24, 3, 1,  0};
      tbl[6]  = '{6, 20, 1'b1, 4'b0001, 24'h000000, 12, 0, 6, 48};
      tbl[7]  = '{6, 32, 1'b1, 4'b0000, 24'h000000, 24, 3, 0,  0};
      tbl[8]  = '{7, 32, 1'b1, 4'b0010, 24'h000000, 24, 3, 0, 48};
      tbl[9]  = '{5,  5, 1'b1, 4'b0001, 24'h000000,  0, 0, 0, 25};
      tbl[10] = '{6, 32, 1'b1, 4'b0000, 24'h000000, 24, 3, 1,  0};
      lens = '{32, 32, 40, 20, 5, 32};

      reset_model();
      idle(3);
      rst_n = 1'b1;
      idle(2);

      for (int i = 0; i < 11; i++) begin
         cnt_h = 0; cnt_v = 0; cnt_e = 0; cnt_inv = 0;
         run_frame(tbl[i].nlines, tbl[i].len, tbl[i].en, tbl[i].fl, tbl[i].fixed, 1'b0);
         chk_int($sformatf("vec%0d h_save", i), cnt_h, tbl[i].exp_h);
         chk_int($sformatf("vec%0d v_save", i), cnt_v, tbl[i].exp_v);
         chk_int($sformatf("vec%0d err", i), cnt_e, tbl[i].exp_e);
         chk_int($sformatf("vec%0d inverted", i), cnt_inv, tbl[i].exp_inv);
      end

      // vs rising together with the first pixel of the frame
      cnt_h = 0; cnt_v = 0; cnt_e = 0;
      run_frame(6, 32, 1'b1, 4'b0110, '0, 1'b1);
      chk_int("vs_on_de h_save", cnt_h, 24);
      chk_int("vs_on_de v_save", cnt_v, 3);
      chk_int("vs_on_de err", cnt_e, 0);

      // asynchronous reset in the middle of a line
      en = 1'b1;
      flags = 4'b0001;
      drive(1'b1, 1'b0, 1'b0, '0);
      idle(2);
      send_line(32, '0, 0);
      for (int p = 0; p < 12; p++) drive(1'b0, 1'b0, 1'b1, 24'hA5A5A5);
      #2 rst_n = 1'b0;
      #1;
      chk_int("async reset outputs",
              int'({de_o, h_save_o, v_save_o, err_o, vid_vs_o, vid_hs_o, vid_de_o}) +
              int'(wd_o != '0) + int'(vid_data_o != '0), 0);
      reset_model();
      vs = 1'b0; hs = 1'b0; de = 1'b0; data = '0;
      idle(2);
      rst_n = 1'b1;
      cnt_h = 0; cnt_v = 0; cnt_e = 0;
      send_line(32, '0, 0);
      send_line(32, '0, 0);
      chk_int("post-reset unsynced h_save", cnt_h, 0);
      chk_int("post-reset unsynced err", cnt_e, 0);
      cnt_h = 0; cnt_v = 0; cnt_e = 0;
      run_frame(6, 32, 1'b1, 4'b0000, '0, 1'b0);
      chk_int("post-reset frame h_save", cnt_h, 24);
      chk_int("post-reset frame v_save", cnt_v, 3);
      chk_int("post-reset frame err", cnt_e, 0);

      // randomized frames checked cycle by cycle against the model
      for (int f = 0; f < 20; f++) begin
         run_frame(int'($urandom_range(4, 7)), lens[$urandom_range(0, 5)],
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), '0,
                   ($urandom_range(0, 4) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
